// File: rtl/arb_mux_reg_pkg.sv
// Shared definitions for the arbitrated registered mux: arbitration modes
// and the index-width helper.
package arb_pkg;

    typedef enum int {
        ARB_FIXED = 0,
        ARB_RR    = 1
    } arb_mode_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_reg_if.sv
// Requester-side and sink-side handshake bundle of the arbitrated mux.
interface arb_mux_reg_if
    import arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4
);
    localparam int SIZE_SEL = clog2_min1(NUM_INPUTS);

    logic [NUM_INPUTS*WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]       in_valid;
    logic [NUM_INPUTS-1:0]       in_ready;
    logic [WIDTH-1:0]            out_data;
    logic [SIZE_SEL-1:0]         out_sel;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/arb_mux_reg_rr_picker.sv
// Combinational requester picker: fixed priority or round-robin starting at
// ptr, using a doubled request vector so the wrap-around needs no special case.
module rr_picker
    import arb_pkg::*;
#(
    parameter int        NUM_INPUTS = 4,
    parameter arb_mode_e MODE       = ARB_RR,
    localparam int       SIZE_SEL   = clog2_min1(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SIZE_SEL-1:0]   ptr,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [SIZE_SEL-1:0]   grant_idx
);

    logic [2*NUM_INPUTS-1:0] dbl;
    logic [2*NUM_INPUTS-1:0] masked;
    logic                    found;
    int unsigned             base;
    int unsigned             idx;

    always_comb begin
        dbl       = {req, req};
        masked    = '0;
        found     = 1'b0;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        base      = (MODE == ARB_RR) ? int'(ptr) : 0;
        // Lower copy is searched from the pointer up; the upper copy supplies the wrapped indices.
        for (int unsigned j = 0; j < 2 * NUM_INPUTS; j++) begin
            masked[j] = dbl[j] && (j >= base);
        end
        for (int unsigned j = 0; j < 2 * NUM_INPUTS; j++) begin
            if (!found && masked[j]) begin
                found = 1'b1;
                idx   = (j >= NUM_INPUTS) ? j - NUM_INPUTS : j;
            end
        end
        if (found) begin
            grant     = NUM_INPUTS'(1) << idx;
            grant_idx = SIZE_SEL'(idx);
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// Arbitrated, registered N-input mux with a valid/ready output stage and a
// round-robin pointer that advances past each winner.
module arb_mux_reg
    import arb_pkg::*;
#(
    parameter int        WIDTH      = 32,
    parameter int        NUM_INPUTS = 4,
    parameter arb_mode_e MODE       = ARB_RR
) (
    input logic          clk,
    input logic          rst_n,
    arb_mux_reg_if.slave bus
);

    localparam int SIZE_SEL = clog2_min1(NUM_INPUTS);

    logic [NUM_INPUTS-1:0] grant;
    logic [SIZE_SEL-1:0]   grant_idx;
    logic [SIZE_SEL-1:0]   ptr;
    logic [SIZE_SEL-1:0]   ptr_next;
    logic                  load_en;
    logic                  xfer;

    rr_picker #(
        .NUM_INPUTS(NUM_INPUTS),
        .MODE      (MODE)
    ) u_picker (
        .req      (bus.in_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    assign load_en      = !bus.out_valid || bus.out_ready;
    assign xfer         = load_en && (|grant);
    assign bus.in_ready = (rst_n && load_en) ? grant : '0;
    assign ptr_next     = (grant_idx == SIZE_SEL'(NUM_INPUTS - 1)) ? '0
                                                                     : grant_idx + SIZE_SEL'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[grant_idx*WIDTH +: WIDTH];
            bus.out_sel   <= grant_idx;
            if (MODE == ARB_RR) begin
                ptr <= ptr_next;
            end
        end else if (bus.out_ready) begin
            // Drain with nothing to refill: data and index are left as they were.
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: round-robin, fixed-priority and a 3-input
// instance, with expected output words queued as each load is requested.
module tb_arb_mux_reg;
    import arb_pkg::*;

    typedef struct packed {
        logic [7:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rsta, rstb, rstc;
    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    logic [3:0] rdy4;
    logic [2:0] rdy3;

    always #5 clk = ~clk;

    arb_mux_reg_if #(.WIDTH(32), .NUM_INPUTS(4)) ifa ();
    arb_mux_reg_if #(.WIDTH(32), .NUM_INPUTS(4)) ifb ();
    arb_mux_reg_if #(.WIDTH(32), .NUM_INPUTS(3)) ifc ();

    arb_mux_reg #(.WIDTH(32), .NUM_INPUTS(4), .MODE(ARB_RR))    dut_a (.clk(clk), .rst_n(rsta), .bus(ifa));
    arb_mux_reg #(.WIDTH(32), .NUM_INPUTS(4), .MODE(ARB_FIXED)) dut_b (.clk(clk), .rst_n(rstb), .bus(ifb));
    arb_mux_reg #(.WIDTH(32), .NUM_INPUTS(3), .MODE(ARB_RR))    dut_c (.clk(clk), .rst_n(rstc), .bus(ifc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_word(input string tag, input bit have, input exp_t e,
                            input logic v, input logic [7:0] sel, input logic [31:0] data);
        chk({tag, "_queued"}, 64'(have), 64'(1'b1));
        chk({tag, "_valid"}, 64'(v), 64'(1'b1));
        chk({tag, "_sel"}, 64'(sel), 64'(e.sel));
        chk({tag, "_data"}, 64'(data), 64'(e.data));
    endtask

    task automatic take_a(input string tag);
        exp_t e = '0;
        bit   have = (qa.size() != 0);
        if (have) e = qa.pop_front();
        cmp_word(tag, have, e, ifa.out_valid, 8'(ifa.out_sel), ifa.out_data);
    endtask

    task automatic take_b(input string tag);
        exp_t e = '0;
        bit   have = (qb.size() != 0);
        if (have) e = qb.pop_front();
        cmp_word(tag, have, e, ifb.out_valid, 8'(ifb.out_sel), ifb.out_data);
    endtask

    task automatic take_c(input string tag);
        exp_t e = '0;
        bit   have = (qc.size() != 0);
        if (have) e = qc.pop_front();
        cmp_word(tag, have, e, ifc.out_valid, 8'(ifc.out_sel), ifc.out_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rsta = 1'b0; rstb = 1'b0; rstc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
            ifb.in_data[i*32 +: 32] = 32'hB0 + 32'(i);
        end
        for (int i = 0; i < 3; i++) ifc.in_data[i*32 +: 32] = 32'hC0 + 32'(i);
        ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1;
        ifb.in_valid = 4'b0000; ifb.out_ready = 1'b0;
        ifc.in_valid = 3'b000;  ifc.out_ready = 1'b0;

        // Reset held with every requester active
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ifa.out_valid), 64'(1'b0));
        chk("rst_ready", 64'(ifa.in_ready), 64'(4'b0000));
        chk("rst_data", 64'(ifa.out_data), 64'(32'h0));
        chk("rst_sel", 64'(ifa.out_sel), 64'(2'd0));
        chk("rst_b_valid", 64'(ifb.out_valid), 64'(1'b0));
        chk("rst_c_valid", 64'(ifc.out_valid), 64'(1'b0));

        // Round-robin over four always-valid inputs
        rsta = 1'b1;
        #1;
        chk("rr_rdy0", 64'(ifa.in_ready), 64'(4'b0001));
        qa.push_back('{8'd0, 32'hA0});
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            take_a("rr");
            if (k < 7) begin
                #1;
                rdy4 = 4'b0001 << (k % 4);
                chk("rr_rdy", 64'(ifa.in_ready), 64'(rdy4));
                qa.push_back('{8'(k % 4), 32'hA0 + 32'(k % 4)});
            end
        end

        // Backpressure on A2
        ifa.out_ready = 1'b0;
        #1;
        chk("stall_rdy0", 64'(ifa.in_ready), 64'(4'b0000));
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(ifa.out_valid), 64'(1'b1));
            chk("stall_data", 64'(ifa.out_data), 64'(32'hA2));
            chk("stall_sel", 64'(ifa.out_sel), 64'(2'd2));
            chk("stall_rdy", 64'(ifa.in_ready), 64'(4'b0000));
        end
        ifa.out_ready = 1'b1;
        #1;
        chk("release_rdy", 64'(ifa.in_ready), 64'(4'b1000));
        qa.push_back('{8'd3, 32'hA3});
        @(posedge clk);
        #1;
        take_a("release");

        // Drain with no requester: word and index are kept
        ifa.in_valid = 4'b0000;
        #1;
        chk("drain_rdy", 64'(ifa.in_ready), 64'(4'b0000));
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(ifa.out_valid), 64'(1'b0));
        chk("drain_data", 64'(ifa.out_data), 64'(32'hA3));
        chk("drain_sel", 64'(ifa.out_sel), 64'(2'd3));

        // Reset pulsed while a word is stalled
        ifa.in_valid  = 4'b0100;
        ifa.out_ready = 1'b0;
        #1;
        chk("pre_rst_rdy", 64'(ifa.in_ready), 64'(4'b0100));
        qa.push_back('{8'd2, 32'hA2});
        @(posedge clk);
        #1;
        take_a("pre_rst");
        ifa.in_valid = 4'b1111;
        #1;
        chk("pre_rst_stall", 64'(ifa.in_ready), 64'(4'b0000));
        rsta = 1'b0;
        #1;
        chk("midrst_valid", 64'(ifa.out_valid), 64'(1'b0));
        chk("midrst_data", 64'(ifa.out_data), 64'(32'h0));
        chk("midrst_rdy", 64'(ifa.in_ready), 64'(4'b0000));
        rsta = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(ifa.in_ready), 64'(4'b0001));
        qa.push_back('{8'd0, 32'hA0});
        @(posedge clk);
        #1;
        take_a("post_rst");
        chk("a_queue_empty", 64'(qa.size()), 64'(0));

        // Fixed priority: input 1 beats input 3 every cycle
        rstb = 1'b1;
        ifb.in_valid  = 4'b1010;
        ifb.out_ready = 1'b1;
        #1;
        chk("fix_rdy0", 64'(ifb.in_ready), 64'(4'b0010));
        qb.push_back('{8'd1, 32'hB1});
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            take_b("fix");
            if (k < 4) begin
                #1;
                chk("fix_rdy", 64'(ifb.in_ready), 64'(4'b0010));
                qb.push_back('{8'd1, 32'hB1});
            end else begin
                ifb.in_valid = 4'b0000;
                #1;
                chk("fix_rdy_idle", 64'(ifb.in_ready), 64'(4'b0000));
            end
        end
        chk("b_queue_empty", 64'(qb.size()), 64'(0));

        // Three inputs: pointer wraps from 2 back to 0
        rstc = 1'b1;
        ifc.in_valid  = 3'b100;
        ifc.out_ready = 1'b1;
        #1;
        chk("wrap_rdy0", 64'(ifc.in_ready), 64'(3'b100));
        qc.push_back('{8'd2, 32'hC2});
        @(posedge clk);
        #1;
        take_c("wrap");
        ifc.in_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            rdy3 = 3'b001 << k;
            chk("wrap_rdy", 64'(ifc.in_ready), 64'(rdy3));
            qc.push_back('{8'(k), 32'hC0 + 32'(k)});
            @(posedge clk);
            #1;
            take_c("wrap");
        end
        ifc.in_valid = 3'b000;
        chk("c_queue_empty", 64'(qc.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
